fetch_ctrl: RTL and testbench

- Sequences the program counter and instruction-memory reads for the multi-cycle MIPS core.
- Owns the PC register and the instruction-memory read handshake, and presents one instruction at a time to decode via valid/ready.
- Applies branch/jump targets after the architectural delay slot.
- Halts the core when control transfers to the halt address.

---
 rtl/fetch_ctrl_pkg.sv | 23 ++
 rtl/fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] DEF_HALT_ADDR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH,
        ISSUE,
        HALT
    } fetch_state_t;

    // Sequential successor, or the saved target once its delay slot is accepted.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc,
                                                input logic            pend,
                                                input logic [XLEN-1:0] pend_target);
        return pend ? pend_target : pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// PC sequencing, instruction-memory read handshake and delayed-branch handling
// for the multi-cycle MIPS core; presents one instruction at a time to decode.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [XLEN-1:0] HALT_ADDR    = DEF_HALT_ADDR
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_address,
    output logic            imem_read,
    input  logic            imem_waitrequest,
    input  logic [XLEN-1:0] imem_readdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            branch_valid,
    input  logic [XLEN-1:0] branch_target,
    output logic            active,
    output logic            fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            fault_q, fault_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= RESET_VECTOR;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            pend_q        <= 1'b0;
            pend_target_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
            fault_q       <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        fault_d       = fault_q;

        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (!imem_waitrequest) begin
                    instr_d       = imem_readdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_valid_q && instr_ready) begin
                    instr_valid_d = 1'b0;
                    pc_d          = next_pc(pc_q, pend_q, pend_target_q);
                    if (pend_q) begin
                        // Delay slot accepted: the saved target takes effect now.
                        pend_d = 1'b0;
                        if (pend_target_q == HALT_ADDR) begin
                            state_d = HALT;
                        end else if (pend_target_q[1:0] != 2'b00) begin
                            fault_d = 1'b1;
                            state_d = HALT;
                        end else begin
                            state_d = FETCH;
                        end
                    end else begin
                        state_d = FETCH;
                        if (branch_valid) begin
                            pend_d        = 1'b1;
                            pend_target_d = branch_target;
                        end
                    end
                end
            end
            HALT: begin
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    assign imem_address = pc_q;
    assign imem_read    = (state_q == FETCH);
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instr_valid  = instr_valid_q;
    assign fault        = fault_q;
    // Gated by reset so the core reads inactive while reset is held.
    assign active       = ~reset & (state_q != HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl: expected fetch and issue traces
// are derived from a per-scenario program of delayed branches.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_waitrequest = 1'b0;
    logic [31:0] imem_readdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        active;
    logic        fault;

    fetch_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_read        (imem_read),
        .imem_waitrequest (imem_waitrequest),
        .imem_readdata    (imem_readdata),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .branch_valid     (branch_valid),
        .branch_target    (branch_target),
        .active           (active),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int hs_count = 0;
    int wait_force = 0;
    bit mon_en = 1'b0;
    bit exp_fault = 1'b0;

    logic [31:0] exp_fetch_q[$];
    logic [31:0] exp_iss_pc_q[$];
    logic [31:0] exp_iss_data_q[$];
    bit          br_dec[$];
    logic [31:0] br_tgt[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h2402_0005;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural trace: a taken branch redirects after one delay slot.
    task automatic build_program(input int n_lim, input logic [31:0] final_tgt,
                                 input int force_k, input logic [31:0] force_tgt);
        logic [31:0] pc, tgt, t;
        bit slot, done, b;
        int k;
        exp_fetch_q.delete(); exp_iss_pc_q.delete(); exp_iss_data_q.delete();
        br_dec.delete(); br_tgt.delete();
        pc = 32'hBFC0_0000; tgt = '0; slot = 0; done = 0; k = 0;
        while (!done) begin
            exp_fetch_q.push_back(pc);
            exp_iss_pc_q.push_back(pc);
            exp_iss_data_q.push_back(memf(pc));
            b = (k >= 8) && ($urandom_range(0, 3) == 0);
            t = 32'hBFC0_0000 | 32'($urandom_range(1, 1023) << 2);
            if (k == force_k) begin b = 1; t = force_tgt; end
            if (k >= n_lim && !slot) begin b = 1; t = final_tgt; end
            br_dec.push_back(b);
            br_tgt.push_back(t);
            if (slot) begin
                pc = tgt; slot = 0;
                if (tgt == 32'h0 || tgt[1:0] != 2'b00) done = 1;
            end else if (b) begin
                pc = pc + 32'd4; slot = 1; tgt = t;
            end else begin
                pc = pc + 32'd4;
            end
            k++;
        end
        exp_fault = (final_tgt != 32'h0) && (final_tgt[1:0] != 2'b00);
        hs_count = 0;
    endtask

    // Memory and decode stimulus, updated just after each active edge.
    always @(posedge clk) begin
        #1;
        if (wait_force > 0) begin
            imem_waitrequest = 1'b1;
            wait_force--;
        end else begin
            imem_waitrequest = ($urandom_range(0, 9) < 3);
        end
        imem_readdata = imem_waitrequest ? $urandom : memf(imem_address);
        instr_ready = ($urandom_range(0, 9) < 6);
        if (instr_ready && hs_count < br_dec.size()) begin
            branch_valid  = br_dec[hs_count];
            branch_target = br_tgt[hs_count];
        end else begin
            branch_valid  = $urandom_range(0, 1);
            branch_target = $urandom;
        end
    end

    // Scoreboard monitor: fetch addresses, delivered instructions, one-outstanding rule.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (imem_read && !imem_waitrequest) begin
                if (exp_fetch_q.size() == 0) begin
                    chk("unexpected_fetch", imem_address, 32'hFFFF_FFFF);
                end else begin
                    chk("fetch_addr", imem_address, exp_fetch_q.pop_front());
                end
            end
            if (instr_valid && instr_ready) begin
                if (exp_iss_pc_q.size() == 0) begin
                    chk("unexpected_issue", instr_pc, 32'hFFFF_FFFF);
                end else begin
                    chk("issue_pc", instr_pc, exp_iss_pc_q.pop_front());
                    chk("issue_instr", instr, exp_iss_data_q.pop_front());
                end
                hs_count++;
            end
            if (imem_read || instr_valid) begin
                chk("read_while_valid", 32'(imem_read && instr_valid), 32'd0);
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        wait_force = 0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_imem_read", 32'(imem_read), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_pc", imem_address, 32'hBFC0_0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_active", 32'(active), 32'd1);
        chk("idle_imem_read", 32'(imem_read), 32'd0);
    endtask

    task automatic run_to_halt(input int first_wait);
        int cyc;
        wait_force = first_wait;
        mon_en = 1'b1;
        cyc = 0;
        while (active && cyc < 4000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("halt_reached", 32'(active), 32'd0);
        chk("fetch_q_drained", 32'(exp_fetch_q.size()), 32'd0);
        chk("issue_q_drained", 32'(exp_iss_pc_q.size()), 32'd0);
        chk("fault_flag", 32'(fault), 32'(exp_fault));
        repeat (3) begin
            @(negedge clk);
            chk("halt_active", 32'(active), 32'd0);
            chk("halt_imem_read", 32'(imem_read), 32'd0);
            chk("halt_instr_valid", 32'(instr_valid), 32'd0);
        end
    endtask

    // Reset during a stalled delay-slot fetch while a branch target is pending.
    task automatic run_abort();
        int cyc;
        build_program(50, 32'h0, 0, 32'hBFC0_0200);
        mon_en = 1'b1;
        cyc = 0;
        while (hs_count < 1 && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("abort_first_accept", 32'(hs_count), 32'd1);
        wait_force = 1000;
        repeat (3) @(negedge clk);
        chk("stall_imem_read", 32'(imem_read), 32'd1);
        chk("stall_addr", imem_address, 32'hBFC0_0004);
        chk("stall_no_valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_imem_read", 32'(imem_read), 32'd0);
        chk("async_active", 32'(active), 32'd0);
        chk("async_pc", imem_address, 32'hBFC0_0000);
        mon_en = 1'b0;
        wait_force = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);

        do_reset();
        build_program(30, 32'h0, -1, 32'h0);
        run_to_halt(4);

        do_reset();
        build_program(20, 32'hBFC0_0102, -1, 32'h0);
        run_to_halt(0);

        do_reset();
        build_program(20, 32'h0, 0, 32'hFFFF_FFF8);
        run_to_halt(0);

        do_reset();
        run_abort();

        do_reset();
        build_program(15, 32'h0, -1, 32'h0);
        run_to_halt(0);

        for (int s = 0; s < 3; s++) begin
            do_reset();
            build_program(25 + s * 5, (s == 1) ? 32'hBFC0_0011 : 32'h0, -1, 32'h0);
            run_to_halt(s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
